// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants, framer state encoding and held-key entry layout.
// Used by ps2_scancode_framer and ps2_held_table.
package ps2_pkg;

    localparam logic [7:0] PS2_E0         = 8'hE0;
    localparam logic [7:0] PS2_E1         = 8'hE1;
    localparam logic [7:0] PS2_F0         = 8'hF0;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

    // Controller status / error bytes that never carry a key code
    localparam logic [7:0] PS2_KEY_ERR0   = 8'h00;
    localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
    localparam logic [7:0] PS2_ECHO       = 8'hEE;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_BAT_FAIL0  = 8'hFC;
    localparam logic [7:0] PS2_BAT_FAIL1  = 8'hFD;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_KEY_ERR1   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GOT_E0   = 3'd1,
        ST_GOT_F0   = 3'd2,
        ST_GOT_E0F0 = 3'd3,
        ST_SKIP_E1  = 3'd4
    } ps2_state_e;

    typedef struct packed {
        logic       valid;
        logic       ext;
        logic [7:0] code;
    } held_entry_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_E0) || (b == PS2_E1) || (b == PS2_F0);
    endfunction

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_KEY_ERR0) || (b == PS2_BAT_OK)    || (b == PS2_ECHO)
            || (b == PS2_ACK)      || (b == PS2_BAT_FAIL0) || (b == PS2_BAT_FAIL1)
            || (b == PS2_RESEND)   || (b == PS2_KEY_ERR1);
    endfunction

endpackage

// File: rtl/ps2_held_table.sv
// Small CAM of currently held keys keyed on {ext, code}; inserts into the
// lowest free slot on a missing make and frees the matching slot on a break.
module ps2_held_table
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         make_i,
    input  logic                         break_i,
    input  logic                         ext_i,
    input  logic [7:0]                   code_i,
    output logic                         hit_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    held_entry_t [DEPTH-1:0] table_q;
    logic [DEPTH-1:0]        hit_vec;
    logic [DEPTH-1:0]        free_vec;
    logic [DEPTH-1:0]        ins_onehot;
    logic [CW-1:0]           cnt;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign hit_vec[gi]  = table_q[gi].valid && (table_q[gi].ext == ext_i)
                              && (table_q[gi].code == code_i);
        assign free_vec[gi] = !table_q[gi].valid;
    end

    // Isolate the lowest set bit of the free mask
    assign ins_onehot = free_vec & (~free_vec + DEPTH'(1));
    assign hit_o      = |hit_vec;
    assign full_o     = (free_vec == '0);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + CW'(table_q[i].valid);
        end
    end
    assign count_o = cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            table_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (make_i && !hit_o && ins_onehot[i]) begin
                    table_q[i] <= '{valid: 1'b1, ext: ext_i, code: code_i};
                end else if (break_i && hit_vec[i]) begin
                    table_q[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_framer.sv
// PS/2 Set-2 byte stream to single-cycle make/break key events with prefix timeout.
// Define PS2_TYPEMATIC_FILTER_EN to build the held-key table that drops auto-repeat makes.
module ps2_scancode_framer
    import ps2_pkg::*;
#(
    parameter int HELD_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                              CLOCK_50,
    input  logic                              resetn,
    input  logic                              byte_valid,
    input  logic [7:0]                        byte_data,
    output logic                              evt_valid,
    output logic [7:0]                        evt_code,
    output logic                              evt_make,
    output logic                              evt_ext,
    output logic                              proto_err,
    output logic [$clog2(HELD_DEPTH+1)-1:0]   held_count,
    output logic                              any_held,
    output logic                              overflow
);

    localparam int CW = $clog2(HELD_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e    state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          evt_valid_q, evt_make_q, evt_ext_q, proto_err_q;
    logic [7:0]    evt_code_q;

    logic key_make, key_break, key_ext, err, to_expire, emit;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        key_make  = 1'b0;
        key_break = 1'b0;
        key_ext   = 1'b0;
        err       = 1'b0;
        to_expire = (state_q != ST_IDLE) && !byte_valid
                    && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        to_cnt_d  = (byte_valid || state_q == ST_IDLE) ? '0 : to_cnt_q + TW'(1);
        if (byte_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_data == PS2_E0)         state_d = ST_GOT_E0;
                    else if (byte_data == PS2_F0)    state_d = ST_GOT_F0;
                    else if (byte_data == PS2_E1) begin
                        state_d = ST_SKIP_E1;
                        skip_d  = 3'd7;
                    end else if (!is_ignored(byte_data)) key_make = 1'b1;
                end
                ST_GOT_E0: begin
                    state_d = ST_IDLE;
                    if (byte_data == PS2_F0)          state_d = ST_GOT_E0F0;
                    else if (is_prefix(byte_data))    err = 1'b1;
                    else if (byte_data != PS2_FAKE_SHIFT) begin
                        key_make = 1'b1;
                        key_ext  = 1'b1;
                    end
                end
                ST_GOT_F0: begin
                    state_d = ST_IDLE;
                    if (is_prefix(byte_data)) err = 1'b1;
                    else                      key_break = 1'b1;
                end
                ST_GOT_E0F0: begin
                    state_d = ST_IDLE;
                    if (is_prefix(byte_data)) err = 1'b1;
                    else if (byte_data != PS2_FAKE_SHIFT) begin
                        key_break = 1'b1;
                        key_ext   = 1'b1;
                    end
                end
                ST_SKIP_E1: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (to_expire) begin
            err     = 1'b1;
            state_d = ST_IDLE;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic          tbl_hit, tbl_full;
    logic [CW-1:0] tbl_count;
    logic          overflow_q, overflow_d;

    ps2_held_table #(
        .DEPTH (HELD_DEPTH)
    ) u_held_table (
        .clk_i   (CLOCK_50),
        .rst_ni  (resetn),
        .make_i  (key_make),
        .break_i (key_break),
        .ext_i   (key_ext),
        .code_i  (byte_data),
        .hit_o   (tbl_hit),
        .full_o  (tbl_full),
        .count_o (tbl_count)
    );

    assign emit       = key_break || (key_make && !tbl_hit);
    assign overflow_d = overflow_q || (key_make && !tbl_hit && tbl_full);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) overflow_q <= 1'b0;
        else         overflow_q <= overflow_d;
    end

    assign held_count = tbl_count;
    assign any_held   = (tbl_count != '0);
    assign overflow   = overflow_q;
`else
    assign emit       = key_make || key_break;
    assign held_count = '0;
    assign any_held   = 1'b0;
    assign overflow   = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            skip_q      <= '0;
            to_cnt_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
            evt_make_q  <= 1'b0;
            evt_ext_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            to_cnt_q    <= to_cnt_d;
            evt_valid_q <= emit;
            proto_err_q <= err;
            if (emit) begin
                evt_code_q <= byte_data;
                evt_make_q <= key_make;
                evt_ext_q  <= key_ext;
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_make  = evt_make_q;
    assign evt_ext   = evt_ext_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ps2_scancode_framer.sv
// Scoreboard bench for ps2_scancode_framer: directed byte sequences push expected
// events/errors into a queue that a negedge monitor pops and compares.
module tb_ps2_scancode_framer;

    localparam int HELD_DEPTH = 4;
    localparam int TIMEOUT    = 40;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       evt_valid, evt_make, evt_ext, proto_err, any_held, overflow;
    logic [7:0] evt_code;
    logic [2:0] held_count;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       make;
        logic       ext;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ps2_scancode_framer #(
        .HELD_DEPTH     (HELD_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_make   (evt_make),
        .evt_ext    (evt_ext),
        .proto_err  (proto_err),
        .held_count (held_count),
        .any_held   (any_held),
        .overflow   (overflow)
    );

    // Monitor: every DUT output strobe must match the head of the queue
    always @(negedge clk) begin
        if (resetn && (evt_valid || proto_err)) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: evt_valid=%0b proto_err=%0b code=%02h required none",
                         evt_valid, proto_err, evt_code);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    if (!proto_err || evt_valid) begin
                        n_fail++;
                        $display("FAIL proto_err: got evt_valid=%0b proto_err=%0b required proto_err=1",
                                 evt_valid, proto_err);
                    end else
                        $display("txn proto_err ok");
                end else if (!evt_valid || proto_err || evt_code !== e.code
                             || evt_make !== e.make || evt_ext !== e.ext) begin
                    n_fail++;
                    $display("FAIL event: got v=%0b err=%0b code=%02h make=%0b ext=%0b required code=%02h make=%0b ext=%0b",
                             evt_valid, proto_err, evt_code, evt_make, evt_ext, e.code, e.make, e.ext);
                end else
                    $display("txn event code=%02h make=%0b ext=%0b ok", evt_code, evt_make, evt_ext);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic exp_evt(input logic [7:0] code, input logic make, input logic ext);
        exp_t e;
        e.is_err = 1'b0; e.code = code; e.make = make; e.ext = ext;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1; e.code = 8'h00; e.make = 1'b0; e.ext = 1'b0;
        exp_q.push_back(e);
    endtask

    // One byte, captured on the next rising edge; returns #1 after that edge
    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b2b [3];
        logic [7:0] e1seq [8];
        logic [7:0] keys [5];
        b2b   = '{8'hE0, 8'hF0, 8'h75};
        e1seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        keys  = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23};

        idle(3);
        check("reset_evt_valid", 32'(evt_valid), 0);
        check("reset_proto_err", 32'(proto_err), 0);
        check("reset_evt_code", 32'(evt_code), 0);
        check("reset_held_count", 32'(held_count), 0);
        resetn = 1'b1;
        idle(2);

        // Single make
        exp_evt(8'h1C, 1'b1, 1'b0);
        send(8'h1C);
        check("make_held_count", 32'(held_count), FILT ? 1 : 0);
        check("make_any_held", 32'(any_held), FILT ? 1 : 0);
        idle(3);
        check("evt_code_holds", 32'(evt_code), 32'h1C);

        // Typematic repeats then release
`ifndef PS2_TYPEMATIC_FILTER_EN
        exp_evt(8'h1C, 1'b1, 1'b0);
        exp_evt(8'h1C, 1'b1, 1'b0);
`endif
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        exp_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        check("release_held_count", 32'(held_count), 0);
        idle(2);

        // Extended make/break, fake shift
        send(8'hE0);
        exp_evt(8'h75, 1'b1, 1'b1);
        send(8'h75);
        check("ext_make_held", 32'(held_count), FILT ? 1 : 0);
        send(8'hE0);
        send(8'hF0);
        exp_evt(8'h75, 1'b0, 1'b1);
        send(8'h75);
        check("ext_break_held", 32'(held_count), 0);
        send(8'hE0);
        send(8'h12);
        send(8'hE0);
        send(8'hF0);
        send(8'h12);
        send(8'hAA);
        send(8'hFA);
        idle(3);

        // Back-to-back E0 F0 75 (break miss still emits)
        exp_evt(8'h75, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_data  = b2b[i];
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        idle(3);

        // Pause sequence swallowed
        foreach (e1seq[i]) send(e1seq[i]);
        exp_evt(8'h1C, 1'b1, 1'b0);
        send(8'h1C);
        send(8'hF0);
        exp_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        idle(2);

        // Illegal prefix orders
        send(8'hF0);
        exp_err();
        send(8'hE0);
        send(8'hE0);
        exp_err();
        send(8'hE0);
        send(8'hE0);
        send(8'hF0);
        exp_err();
        send(8'hE1);
        idle(3);

        // Timeout: long gap after E0, then a fresh make
        send(8'hE0);
        exp_err();
        idle(TIMEOUT + 5);
        exp_evt(8'h23, 1'b1, 1'b0);
        send(8'h23);
        send(8'hF0);
        exp_evt(8'h23, 1'b0, 1'b0);
        send(8'h23);

        // Byte lands on the expiry edge: byte wins
        send(8'hE0);
        repeat (TIMEOUT - 2) @(posedge clk);
        exp_evt(8'h75, 1'b1, 1'b1);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        exp_evt(8'h75, 1'b0, 1'b1);
        send(8'h75);

        // One cycle later: timeout fires first, byte is a plain make
        send(8'hE0);
        repeat (TIMEOUT - 1) @(posedge clk);
        exp_err();
        exp_evt(8'h75, 1'b1, 1'b0);
        send(8'h75);
        send(8'hF0);
        exp_evt(8'h75, 1'b0, 1'b0);
        send(8'h75);
        check("pre_fill_held", 32'(held_count), 0);

        // Fill table past capacity
        for (int i = 0; i < 5; i++) begin
            exp_evt(keys[i], 1'b1, 1'b0);
            send(keys[i]);
            if (i == 3) check("overflow_not_yet", 32'(overflow), 0);
        end
        check("full_held_count", 32'(held_count), FILT ? 4 : 0);
        check("overflow_set", 32'(overflow), FILT ? 1 : 0);
        idle(2);

        // Reset mid-sequence
        send(8'hF0);
        resetn = 1'b0;
        #2;
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_evt_code", 32'(evt_code), 0);
        check("rst_flags", 32'({evt_make, evt_ext, proto_err, any_held}), 0);
        check("rst_held_count", 32'(held_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        idle(2);
        resetn = 1'b1;
        exp_evt(8'h1C, 1'b1, 1'b0);
        send(8'h1C);
        check("post_rst_held", 32'(held_count), FILT ? 1 : 0);

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
